easyaxi_fifo_wr_arb: RTL and testbench
======================================

Name: easyaxi_fifo_wr_arb

Overview:
Round-robin write arbiter and occupancy controller for one shared EasyAXI FIFO instance.
- N requesters present data with valid/ready; one is granted per cycle.
- Granted data is tagged with its source index and pushed into the FIFO.
- The read side is drained to a single valid/ready master, which returns the source tag.
- Per-source occupancy counters enforce a quota, so one source cannot monopolise FIFO depth.

Parameters:
N_SRC, 4, number of requesters (>=2)
DATA_WIDTH, 8, payload width per requester
SRC_W, 2, source tag width, equals $clog2(N_SRC)
DEPTH, 16, depth of the attached FIFO (power of two)
QUOTA, 4, maximum entries one source may hold in the FIFO (1..DEPTH)
CNT_W, 5, counter width, equals $clog2(DEPTH+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  N_SRC  per-source request valid
s_ready  out  N_SRC  per-source accept, one-hot or zero
s_data  in  N_SRC*DATA_WIDTH  flattened payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
fifo_wr  out  1  FIFO push strobe
fifo_wdata  out  SRC_W+DATA_WIDTH  {src_tag, payload}
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd  out  1  FIFO pop strobe
fifo_rdata  in  SRC_W+DATA_WIDTH  FIFO head entry (combinational head)
m_valid  out  1  drain-side valid
m_ready  in  1  drain-side ready
m_data  out  DATA_WIDTH  head payload
m_src  out  SRC_W  head source tag
src_cnt  out  N_SRC*CNT_W  flattened per-source occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): all src_cnt=0; rr_ptr=N_SRC-1, so source 0 has first priority. Outputs s_ready=0, fifo_wr=0, fifo_rd=0, m_valid=0. The attached FIFO is reset on the same event.
- Eligibility: elig[i] = s_valid[i] & ~fifo_full & (cnt[i] < QUOTA).
- Grant (combinational): first eligible index scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo N_SRC.
  - s_ready[grant]=1; all other s_ready bits 0.
  - No eligible source gives s_ready=0.
- Push: fifo_wr = |s_ready; fifo_wdata = {grant_idx, s_data[grant_idx]}. Zero latency from handshake to push.
- rr_ptr <= grant_idx only on a push cycle; otherwise it holds.
- Full handling: fifo_full blocks all grants, even if a pop happens in the same cycle. No write-through-full, so the FIFO never sees wr while full.
- Drain: m_valid = ~fifo_empty; m_data/m_src = fifo_rdata fields; fifo_rd = m_valid & m_ready. The FIFO never sees rd while empty.
- Counters (registered):
  - cnt[i] +1 on push from i.
  - cnt[i] -1 on pop with head tag i.
  - Push and pop for the same i in one cycle: net unchanged.
  - Counters never exceed QUOTA and never underflow. An underflow attempt is a design error; the simulation assertion fires.
- Invariant: sum(cnt) equals the FIFO occupancy at all times.
- Data ordering: global FIFO order, so per-source order is preserved.
- s_valid deasserted without a handshake is legal; no internal state changes.
- Reset mid-operation: pending entries are discarded, counters clear, and the grant pointer returns to its reset value. Requesters must re-present their data.

Decomposition:
- Package easyaxi_arb_pkg: src tag width function, entry packing/unpacking helpers, QUOTA/DEPTH sanity checks (QUOTA<=DEPTH, DEPTH power of two).
- Sub-module easyaxi_rr_picker: combinational round-robin find-first from (req vector, rr_ptr) to (grant one-hot, grant_idx, any). Reusable by future read-channel arbiters.
- Counters and handshake glue stay in the top module.

Test Plan:
- All 4 sources are valid continuously, m_ready=1 -> grants 0,1,2,3,0,1,... one per cycle; m_src follows the same sequence; each src_cnt stays <=1.
- Only source 2 is valid, m_ready=0 -> 4 pushes accepted (cnt[2]=4=QUOTA), then s_ready[2]=0. Sources 0/1/3 are still granted until the FIFO holds 16, then fifo_full blocks everyone.
- FIFO full (16 entries), m_ready pulses for one cycle -> exactly one pop. No push that cycle; push resumes the next cycle. Counters update for both events.
- Source 1 pushes while its own head entry pops in the same cycle -> cnt[1] unchanged; data order 0xA1 then 0xA2 is preserved on m_data.
- Assert rst with 7 entries queued and cnt={3,2,1,1} -> next cycle all counters 0, m_valid=0, first grant goes to source 0.
- Sources 0 and 3 are valid, rr_ptr=3 -> source 0 is granted, then source 3. Deasserting s_valid[3] before grant changes no state.

Source files
------------

// File: rtl/easyaxi_arb_pkg.sv
// Shared helpers for EasyAXI FIFO arbiters: tag/counter widths, entry packing
// and parameter sanity checks.
package easyaxi_arb_pkg;

  // Upper bounds for the generic packing helpers; callers truncate to their width.
  localparam int unsigned MaxSrcW   = 16;
  localparam int unsigned MaxDataW  = 256;
  localparam int unsigned MaxEntryW = MaxSrcW + MaxDataW;

  typedef logic [MaxEntryW-1:0] entry_wide_t;

  // Source tag width for n_src requesters (at least one bit).
  function automatic int unsigned src_tag_w(int unsigned n_src);
    return (n_src <= 1) ? 1 : $clog2(n_src);
  endfunction

  // Occupancy counter width able to hold 0..depth.
  function automatic int unsigned occ_cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // All structural parameter relationships the arbiter relies on.
  function automatic bit params_ok(int unsigned n_src, int unsigned data_w,
                                   int unsigned src_w, int unsigned depth,
                                   int unsigned quota, int unsigned cnt_w);
    return (n_src >= 2) && (src_w == src_tag_w(n_src)) && (src_w <= MaxSrcW) &&
           (data_w >= 1) && (data_w <= MaxDataW) && is_pow2(depth) &&
           (quota >= 1) && (quota <= depth) && (cnt_w == occ_cnt_w(depth));
  endfunction

  function automatic entry_wide_t data_mask(int unsigned data_w);
    return (entry_wide_t'(1) << data_w) - entry_wide_t'(1);
  endfunction

  // Entry layout is {src_tag, payload} with the payload in the low data_w bits.
  function automatic entry_wide_t pack_entry(int unsigned data_w, entry_wide_t src,
                                             entry_wide_t data);
    return (src << data_w) | (data & data_mask(data_w));
  endfunction

  function automatic entry_wide_t unpack_data(int unsigned data_w, entry_wide_t entry);
    return entry & data_mask(data_w);
  endfunction

  function automatic entry_wide_t unpack_src(int unsigned data_w, entry_wide_t entry);
    return entry >> data_w;
  endfunction

endpackage

// File: rtl/easyaxi_rr_picker.sv
// Combinational round-robin find-first: scans ptr+1, ptr+2, ... (mod N) and
// grants the first requesting index.
module easyaxi_rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand     = (32'(ptr_i) + off) % N;
      cand_idx = IdxW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/easyaxi_fifo_wr_arb.sv
// Round-robin write arbiter and per-source occupancy controller for one shared
// EasyAXI FIFO. Granted data is tagged with its source and pushed the same
// cycle; the FIFO head drains to a single valid/ready master.
module easyaxi_fifo_wr_arb
  import easyaxi_arb_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SRC_W      = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned QUOTA      = 4,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            s_valid,
  output logic [N_SRC-1:0]            s_ready,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_data,
  output logic                        fifo_wr,
  output logic [SRC_W+DATA_WIDTH-1:0] fifo_wdata,
  input  logic                        fifo_full,
  input  logic                        fifo_empty,
  output logic                        fifo_rd,
  input  logic [SRC_W+DATA_WIDTH-1:0] fifo_rdata,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [SRC_W-1:0]            m_src,
  output logic [N_SRC*CNT_W-1:0]      src_cnt
);

  localparam int unsigned EntryW = SRC_W + DATA_WIDTH;

  if (!params_ok(N_SRC, DATA_WIDTH, SRC_W, DEPTH, QUOTA, CNT_W)) begin : g_param_err
    $error("easyaxi_fifo_wr_arb: inconsistent parameters");
  end

  logic [N_SRC-1:0]      below_quota;
  logic [N_SRC-1:0]      elig;
  logic [N_SRC-1:0]      gnt;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q [N_SRC];
  logic [CNT_W-1:0]      cnt_d [N_SRC];
  logic [N_SRC-1:0]      push_vec;
  logic [N_SRC-1:0]      pop_vec;

  // Eligibility: valid, room in the FIFO (a same-cycle pop does not help), under quota.
  always_comb begin
    below_quota = '0;
    for (int i = 0; i < N_SRC; i++) begin
      below_quota[i] = (cnt_q[i] < CNT_W'(QUOTA));
    end
    elig = s_valid & below_quota & {N_SRC{~fifo_full & ~rst}};
  end

  easyaxi_rr_picker #(
    .N    (N_SRC),
    .IdxW (SRC_W)
  ) u_picker (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (grant_idx),
    .any_o (grant_any)
  );

  // Write side: handshake and push happen in the same cycle.
  always_comb begin
    s_ready    = gnt;
    fifo_wr    = grant_any;
    grant_data = s_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    fifo_wdata = EntryW'(pack_entry(DATA_WIDTH, entry_wide_t'(grant_idx),
                                    entry_wide_t'(grant_data)));
  end

  // Read side: head entry is presented directly; pop on handshake only.
  always_comb begin
    m_valid = ~fifo_empty & ~rst;
    fifo_rd = m_valid & m_ready;
    m_data  = DATA_WIDTH'(unpack_data(DATA_WIDTH, entry_wide_t'(fifo_rdata)));
    m_src   = SRC_W'(unpack_src(DATA_WIDTH, entry_wide_t'(fifo_rdata)));
  end

  // Per-source push/pop events and next-state counters and pointer.
  always_comb begin
    push_vec = gnt;
    pop_vec  = '0;
    rr_ptr_d = fifo_wr ? grant_idx : rr_ptr_q;
    for (int i = 0; i < N_SRC; i++) begin
      pop_vec[i] = fifo_rd && (m_src == SRC_W'(i));
      case ({push_vec[i], pop_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // State registers; the pointer resets to the last index so source 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= SRC_W'(N_SRC - 1);
      cnt_q    <= '{default: '0};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < N_SRC; i++) begin
        if (pop_vec[i] && !push_vec[i]) begin
          assert (cnt_q[i] != '0)
            else $error("easyaxi_fifo_wr_arb: occupancy underflow on source %0d", i);
        end
        if (push_vec[i] && !pop_vec[i]) begin
          assert (cnt_q[i] < CNT_W'(QUOTA))
            else $error("easyaxi_fifo_wr_arb: quota overflow on source %0d", i);
        end
      end
    end
  end

  // Flatten counters for observation.
  always_comb begin
    src_cnt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_easyaxi_fifo_wr_arb.sv
// Bench for easyaxi_fifo_wr_arb: behavioural FIFO attached to the DUT, a
// reference model whose queue acts as the scoreboard, a vector table for the
// round-robin sequence and hand-written sequences for quota/full/reset cases.
module tb_easyaxi_fifo_wr_arb;

  localparam int N = 4, DW = 8, SW = 2, DEPTH = 16, QUOTA = 4, CW = 5, EW = SW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    s_valid, s_ready;
  logic [N*DW-1:0] s_data;
  logic            fifo_wr, fifo_full, fifo_empty, fifo_rd;
  logic [EW-1:0]   fifo_wdata, fifo_rdata;
  logic            m_valid, m_ready;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_src;
  logic [N*CW-1:0] src_cnt;

  easyaxi_fifo_wr_arb #(
    .N_SRC(N), .DATA_WIDTH(DW), .SRC_W(SW), .DEPTH(DEPTH), .QUOTA(QUOTA), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_src(m_src),
    .src_cnt(src_cnt)
  );

  initial forever #5 clk = ~clk;

  // Attached FIFO, reset on the same event as the arbiter.
  logic [EW-1:0] mem [DEPTH];
  logic [3:0]    wp, rp;
  logic [4:0]    occ;

  always_ff @(posedge clk) begin
    if (fifo_wr && !fifo_full) mem[wp] <= fifo_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0; rp <= '0; occ <= '0;
    end else begin
      if (fifo_wr && !fifo_full) wp <= wp + 4'd1;
      if (fifo_rd && !fifo_empty) rp <= rp + 4'd1;
      occ <= occ + 5'(fifo_wr && !fifo_full) - 5'(fifo_rd && !fifo_empty);
    end
  end

  assign fifo_full  = (occ == 5'(DEPTH));
  assign fifo_empty = (occ == 5'd0);
  assign fifo_rdata = mem[rp];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model; mq is the scoreboard of entries expected from the FIFO.
  int            mptr;
  int            mcnt [N];
  logic [EW-1:0] mq [$];

  function automatic int exp_grant();
    if (mq.size() >= DEPTH) return -1;
    for (int off = 1; off <= N; off++) begin
      int c = (mptr + off) % N;
      if (s_valid[c] && mcnt[c] < QUOTA) return c;
    end
    return -1;
  endfunction

  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(mcnt[i]);
    return v;
  endfunction

  // One clock: compare everything against the model at the falling edge, then advance it.
  task automatic tick();
    int            g;
    logic          pop;
    logic [EW-1:0] e, w;
    g   = exp_grant();
    pop = (mq.size() > 0) && m_ready;
    @(negedge clk);
    check("s_ready", 32'(s_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("fifo_wr", 32'(fifo_wr), 32'(g >= 0));
    check("wr_while_full", 32'(fifo_wr & fifo_full), 32'd0);
    if (g >= 0) begin
      w = {g[SW-1:0], s_data[g*DW +: DW]};
      check("fifo_wdata", 32'(fifo_wdata), 32'(w));
    end
    check("m_valid", 32'(m_valid), 32'(mq.size() > 0));
    check("fifo_rd", 32'(fifo_rd), 32'(pop));
    if (mq.size() > 0) begin
      e = mq[0];
      check("m_src", 32'(m_src), 32'(e[EW-1:DW]));
      check("m_data", 32'(m_data), 32'(e[DW-1:0]));
    end
    check("src_cnt", 32'(src_cnt), 32'(exp_cnt()));
    if (pop) begin
      e = mq.pop_front();
      mcnt[e[EW-1:DW]]--;
    end
    if (g >= 0) begin
      mq.push_back(w);
      mcnt[g]++;
      mptr = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = '0; m_ready = 1'b0; s_data = '0;
    #3;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_src_cnt", 32'(src_cnt), 32'd0);
    mptr = N - 1;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_data(input int k);
    for (int i = 0; i < N; i++) s_data[i*DW +: DW] = DW'(16 * i + k);
  endtask

  typedef struct {
    logic [N-1:0]  sv;
    logic          mr;
    logic [N-1:0]  exp_rdy;
    logic          exp_mv;
    logic [SW-1:0] exp_src;
  } vec_t;

  vec_t vec [8];
  int   seq = 0;

  initial begin
    vec[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vec[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vec[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    vec[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    vec[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    vec[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vec[6] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
    vec[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    s_valid = '0; m_ready = 1'b0; s_data = '0;
    #1;
    do_reset();

    // Round-robin with all sources valid and the drain always ready.
    for (int k = 0; k < 8; k++) begin
      s_valid = vec[k].sv;
      m_ready = vec[k].mr;
      set_data(k);
      #3;
      check("tbl_s_ready", 32'(s_ready), 32'(vec[k].exp_rdy));
      check("tbl_m_valid", 32'(m_valid), 32'(vec[k].exp_mv));
      if (vec[k].exp_mv) check("tbl_m_src", 32'(m_src), 32'(vec[k].exp_src));
      tick();
    end

    // Quota on source 2, then fill to full with the others.
    do_reset();
    s_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin set_data(seq++); tick(); end
    #3;
    check("quota_block", 32'(s_ready), 32'd0);
    check("quota_cnt", 32'(src_cnt), 32'h0_1000);
    tick();
    s_valid = 4'b1111;
    for (int k = 0; k < 14; k++) begin set_data(seq++); tick(); end
    #3;
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_block", 32'(s_ready), 32'd0);
    check("full_cnt", 32'(src_cnt), 32'h2_1084);
    tick();

    // One-cycle drain pulse while full: pop only, push resumes next cycle.
    m_ready = 1'b1;
    #3;
    check("pulse_rd", 32'(fifo_rd), 32'd1);
    check("pulse_no_push", 32'(s_ready), 32'd0);
    check("pulse_head_src", 32'(m_src), 32'd2);
    tick();
    m_ready = 1'b0;
    #3;
    check("resume_grant", 32'(s_ready), 32'b0100);
    check("resume_cnt", 32'(src_cnt), 32'h2_0C84);
    tick();
    #3;
    check("refull_cnt", 32'(src_cnt), 32'h2_1084);
    tick();

    // Same-source push and pop in one cycle.
    do_reset();
    s_valid = 4'b0010;
    s_data[15:8] = 8'hA1;
    tick();
    s_data[15:8] = 8'hA2;
    m_ready = 1'b1;
    #3;
    check("same_head_a1", 32'(m_data), 32'hA1);
    check("same_grant", 32'(s_ready), 32'b0010);
    check("same_cnt_pre", 32'(src_cnt), 32'h20);
    tick();
    s_valid = '0;
    #3;
    check("same_head_a2", 32'(m_data), 32'hA2);
    check("same_cnt_net", 32'(src_cnt), 32'h20);
    tick();
    #3;
    check("same_empty", 32'(m_valid), 32'd0);
    tick();

    // Reset with 7 entries queued.
    do_reset();
    s_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin set_data(seq++); tick(); end
    s_valid = 4'b0011;
    for (int k = 0; k < 2; k++) begin set_data(seq++); tick(); end
    s_valid = 4'b0001;
    set_data(seq++);
    tick();
    s_valid = '0;
    #3;
    check("pre_rst_cnt", 32'(src_cnt), 32'h8443);
    check("pre_rst_mv", 32'(m_valid), 32'd1);
    do_reset();
    s_valid = 4'b1111;
    #3;
    check("post_rst_grant", 32'(s_ready), 32'b0001);
    tick();

    // Sources 0 and 3 from the reset pointer; withdrawn request leaves no trace.
    do_reset();
    s_valid = 4'b1001;
    set_data(seq++);
    #3;
    check("p03_first", 32'(s_ready), 32'b0001);
    tick();
    #3;
    check("p03_second", 32'(s_ready), 32'b1000);
    tick();
    #3;
    check("p03_third", 32'(s_ready), 32'b0001);
    tick();
    s_valid = '0;
    #3;
    check("p03_withdraw_cnt", 32'(src_cnt), 32'h8002);
    tick();
    s_valid = 4'b1000;
    #3;
    check("p03_ptr_held", 32'(s_ready), 32'b1000);
    tick();
    s_valid = '0;
    #3;
    check("p03_cnt", 32'(src_cnt), 32'h1_0002);
    tick();

    // Drain everything.
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    #3;
    check("drain_cnt", 32'(src_cnt), 32'd0);
    check("drain_mv", 32'(m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
